winograd_input_transform_2d: RTL and testbench
==============================================

WINOGRAD_INPUT_TRANSFORM_2D -- requirements
Module: winograd_input_transform_2d

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed input element width.
REQ-002 SHALL have parameter OUT_W, default DATA_W+8 (24), signed output element width; OUT_W >= DATA_W+7.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  one input tile row is presented.
REQ-006 SHALL have port in_ready  output  1  block accepts an input row this cycle.
REQ-007 SHALL have port in_row  input  6xDATA_W signed  row d[r][0..5] of the 6x6 input tile, rows in order r=0..5.
REQ-008 SHALL have port out_valid  output  1  one transformed row is presented.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the row.
REQ-010 SHALL have port out_row  output  6xOUT_W signed  row V[i][0..5] of V = B^T*d*B.
REQ-011 SHALL have port out_idx  output  3  row index i (0..5) of out_row.
REQ-012 SHALL have port out_last  output  1  high with out_valid when out_idx==5.

Function
REQ-013 SHALL implement Winograd F(4,3) input transform, B^T rows: [4 0 -5 0 1 0], [0 -4 -4 1 1 0], [0 4 -4 -1 1 0], [0 -2 -1 2 1 0], [0 2 -1 -2 1 0], [0 4 0 -5 0 1].
REQ-014 SHALL, on each accepted input beat (in_valid && in_ready), store the row transform T[r][j] = sum_k B^T[j][k]*d[r][k] into row r of a 6x6 buffer of width DATA_W+4.
REQ-015 SHALL use shift-and-add only (4x = <<<2, 5x = <<<2 + x, 2x = <<<1); no multipliers.
REQ-016 SHALL sign-extend all operands and compute full precision; no saturation, no rounding.
REQ-017 SHALL have two states: LOAD (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-018 SHALL count accepted rows 0..5 in LOAD; the sixth accepted row moves LOAD->DRAIN at that clock edge, and the load counter returns to 0.
REQ-019 SHALL present in DRAIN out_row[j] = sum_k B^T[out_idx][k]*T[k][j], a combinational function of the buffer and out_idx.
REQ-020 SHALL advance out_idx only on out_valid && out_ready; out_row, out_idx and out_last SHALL stay stable while out_valid && !out_ready.
REQ-021 SHALL, on handshake with out_idx==5, return to LOAD at that edge and reset out_idx to 0; in_ready becomes 1 the next cycle.
REQ-022 SHALL give latency: first output row valid the cycle after the sixth input row is accepted; a tile takes at least 12 cycles with no stalls.
REQ-023 SHALL ignore in_row and in_valid while in DRAIN and ignore out_ready while in LOAD.
REQ-024 SHALL let an in_valid gap in LOAD hold the row counter; partial tiles are kept until completed.

Reset
REQ-025 SHALL, on rst_n low, immediately enter LOAD with row counter 0, out_idx 0, out_valid 0, out_last 0 and in_ready 1 after release.
REQ-026 SHALL need no buffer reset; out_row is don't-care while out_valid=0.
REQ-027 SHALL, on reset mid-LOAD or mid-DRAIN, discard the partial or undrained tile; the first tile after release is rows 0..5 anew.

Verification
REQ-028 SHALL have a test: tile of all 1s -> V[1][1]=36, all other 35 elements 0; out_last on the sixth output beat only.
REQ-029 SHALL have a test: impulse d[0][0]=1, rest 0 -> V[0][0]=16, all others 0.
REQ-030 SHALL have a test: d[2][2]=-32768, rest 0 -> V[i][j]=-32768*c_i*c_j with c=[-5,-4,-4,-1,-1,0]; V[0][0]=-819200 (OUT_W=24), row 5 and column 5 all 0.
REQ-031 SHALL have a test: out_ready low 3 cycles at out_idx=2 -> out_row/out_idx held, in_ready stays 0, no row skipped or repeated.
REQ-032 SHALL have a test: back-to-back tiles, in_valid always 1, out_ready always 1 -> 6 accepts, 6 outputs, repeat, 12-cycle period, results match a golden model.
REQ-033 SHALL have a test: rst_n pulsed after 3 accepted rows and again at out_idx=4 -> out_valid 0 immediately, in_ready 1 after release, next full tile correct.

Source files
------------

// File: rtl/winograd_input_transform_2d.sv
// Winograd F(4,3) 2-D input transform: V = B^T * d * B on 6x6 tiles.
// Rows stream in, are row-transformed into a buffer, then drained column-transformed.
module winograd_input_transform_2d #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*DATA_W-1:0]   in_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*OUT_W-1:0]    out_row,
    output logic [2:0]            out_idx,
    output logic                  out_last
);

    localparam int TW = DATA_W + 4;

    localparam logic LOAD  = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic                 state;
    logic [2:0]           row_cnt;
    logic signed [DATA_W-1:0] d [6];
    logic signed [TW-1:0] trow [6];
    logic signed [TW-1:0] tbuf [6][6];

    // One B^T row applied to six operands, shift-and-add only.
    function automatic logic signed [OUT_W-1:0] bt(
        input logic [2:0]              sel,
        input logic signed [OUT_W-1:0] x0,
        input logic signed [OUT_W-1:0] x1,
        input logic signed [OUT_W-1:0] x2,
        input logic signed [OUT_W-1:0] x3,
        input logic signed [OUT_W-1:0] x4,
        input logic signed [OUT_W-1:0] x5
    );
        logic signed [OUT_W-1:0] r;
        unique case (sel)
            3'd0:    r = (x0 <<< 2) - ((x2 <<< 2) + x2) + x4;
            3'd1:    r = x3 + x4 - (x1 <<< 2) - (x2 <<< 2);
            3'd2:    r = (x1 <<< 2) - (x2 <<< 2) - x3 + x4;
            3'd3:    r = (x3 <<< 1) - (x1 <<< 1) - x2 + x4;
            3'd4:    r = (x1 <<< 1) - x2 - (x3 <<< 1) + x4;
            default: r = (x1 <<< 2) - ((x3 <<< 2) + x3) + x5;
        endcase
        return r;
    endfunction

    function automatic logic signed [OUT_W-1:0] ext_d(
        input logic signed [DATA_W-1:0] v
    );
        return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [OUT_W-1:0] ext_t(
        input logic signed [TW-1:0] v
    );
        return {{(OUT_W-TW){v[TW-1]}}, v};
    endfunction

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (out_idx == 3'd5);

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            d[k] = in_row[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < 6; j++) begin
            trow[j] = TW'(bt(3'(j), ext_d(d[0]), ext_d(d[1]),
                             ext_d(d[2]), ext_d(d[3]),
                             ext_d(d[4]), ext_d(d[5])));
        end
    end

    // Tile storage carries no reset; control state alone decides validity.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            for (int j = 0; j < 6; j++) begin
                tbuf[row_cnt][j] <= trow[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            row_cnt <= 3'd0;
            out_idx <= 3'd0;
        end else if (state == LOAD) begin
            if (in_valid) begin
                if (row_cnt == 3'd5) begin
                    row_cnt <= 3'd0;
                    state   <= DRAIN;
                end else begin
                    row_cnt <= row_cnt + 3'd1;
                end
            end
        end else begin
            if (out_ready) begin
                if (out_idx == 3'd5) begin
                    out_idx <= 3'd0;
                    state   <= LOAD;
                end else begin
                    out_idx <= out_idx + 3'd1;
                end
            end
        end
    end

    always_comb begin
        out_row = '0;
        for (int j = 0; j < 6; j++) begin
            out_row[j*OUT_W +: OUT_W] =
                bt(out_idx, ext_t(tbuf[0][j]), ext_t(tbuf[1][j]),
                   ext_t(tbuf[2][j]), ext_t(tbuf[3][j]),
                   ext_t(tbuf[4][j]), ext_t(tbuf[5][j]));
        end
    end

endmodule

// File: tb/tb_winograd_input_transform_2d.sv
// Bench for winograd_input_transform_2d: directed and random tiles
// checked against a matrix-product reference model.
module tb_winograd_input_transform_2d;

    localparam int DW = 16;
    localparam int OW = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6*DW-1:0]   in_row = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [6*OW-1:0]   out_row;
    logic [2:0]        out_idx;
    logic              out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int prev_start = 0;

    int bt_m [6][6] = '{
        '{4,  0, -5,  0, 1, 0},
        '{0, -4, -4,  1, 1, 0},
        '{0,  4, -4, -1, 1, 0},
        '{0, -2, -1,  2, 1, 0},
        '{0,  2, -1, -2, 1, 0},
        '{0,  4,  0, -5, 0, 1}
    };
    int tile [6][6];
    int expv [6][6];
    int got  [6][6];

    winograd_input_transform_2d #(.DATA_W(DW), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [6*OW-1:0] obs,
                       input logic [6*OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // V = B^T * d * B via plain integer matrix products.
    task automatic model();
        int m [6][6];
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 6; j++) begin
                m[r][j] = 0;
                for (int k = 0; k < 6; k++)
                    m[r][j] += tile[r][k] * bt_m[j][k];
            end
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                expv[i][j] = 0;
                for (int k = 0; k < 6; k++)
                    expv[i][j] += bt_m[i][k] * m[k][j];
            end
    endtask

    task automatic fill(input int mode);
        logic [DW-1:0] u;
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 6; k++) begin
                u = DW'($urandom);
                case ($urandom_range(0, 5))
                    0: u = 16'h8000;
                    1: u = 16'h7fff;
                    default: ;
                endcase
                case (mode)
                    0: tile[r][k] = 1;
                    1: tile[r][k] = (r == 0 && k == 0) ? 1 : 0;
                    2: tile[r][k] = (r == 2 && k == 2) ? -32768 : 0;
                    default: tile[r][k] = int'($signed(u));
                endcase
            end
        model();
    endtask

    function automatic logic [6*DW-1:0] pack(input int r);
        logic [6*DW-1:0] v;
        for (int k = 0; k < 6; k++) v[k*DW +: DW] = DW'(tile[r][k]);
        return v;
    endfunction

    function automatic logic [6*OW-1:0] erow(input int i);
        logic [6*OW-1:0] v;
        for (int j = 0; j < 6; j++) v[j*OW +: OW] = OW'(expv[i][j]);
        return v;
    endfunction

    task automatic junk_row();
        for (int k = 0; k < 6; k++) in_row[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic load(input int gap_at, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            if (r == gap_at) begin
                @(negedge clk);
                chk("gap_ctl", {in_ready, out_valid}, 2'b10);
                in_valid = 1'b0;
                junk_row();
            end
            @(negedge clk);
            chk("load_ctl", {in_ready, out_valid, out_last}, 3'b100);
            if (r == 0) begin
                prev_start = start_cyc;
                start_cyc  = cyc;
            end
            in_valid  = 1'b1;
            in_row    = pack(r);
            out_ready = 1'($urandom);
        end
    endtask

    task automatic out_step(input int i, input bit rdy, input bit keep);
        @(negedge clk);
        chk("out_ctl", {out_valid, in_ready, out_idx, out_last},
            {1'b1, 1'b0, 3'(i), (i == 5)});
        chk("out_row", out_row, erow(i));
        for (int j = 0; j < 6; j++)
            got[i][j] = int'($signed(out_row[j*OW +: OW]));
        out_ready = rdy;
        in_valid  = keep;
        junk_row();
    endtask

    task automatic drain(input int stall_at, input int stall_n,
                         input bit keep, input int upto);
        for (int i = 0; i < upto; i++) begin
            if (i == stall_at)
                for (int s = 0; s < stall_n; s++) out_step(i, 1'b0, keep);
            out_step(i, 1'b1, keep);
        end
    endtask

    initial begin
        #1;
        chk("rst_ctl", {out_valid, out_last, in_ready, out_idx}, 6'b001000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fill(0); load(-1, 6); drain(-1, 0, 1'b0, 6);
        chk("ones_v11", got[1][1], 36);
        chk("ones_v00", got[0][0], 0);
        chk("ones_v55", got[5][5], 0);

        fill(1); load(-1, 6); drain(-1, 0, 1'b0, 6);
        chk("imp_v00", got[0][0], 16);

        fill(2); load(-1, 6); drain(2, 3, 1'b1, 6);
        chk("neg_v00", got[0][0], -819200);
        chk("neg_v15", got[1][5], 0);
        chk("neg_v52", got[5][2], 0);

        fill(3); load(3, 6); drain(-1, 0, 1'b0, 6);

        for (int t = 0; t < 3; t++) begin
            fill(3); load(-1, 6);
            if (t > 0) chk("period", start_cyc - prev_start, 12);
            drain(-1, 0, 1'b1, 6);
        end

        fill(3); load(-1, 3);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_load", {out_valid, out_last, in_ready}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        fill(3); load(-1, 6); drain(-1, 0, 1'b0, 6);

        fill(3); load(-1, 6); drain(-1, 0, 1'b0, 4);
        @(negedge clk);
        chk("pre_rst_idx", {out_valid, out_idx}, {1'b1, 3'd4});
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_drain", {out_valid, out_last, in_ready, out_idx}, 6'b001000);
        @(negedge clk);
        rst_n = 1'b1;
        fill(3); load(-1, 6); drain(1, 2, 1'b0, 6);

        @(negedge clk);
        chk("idle_ctl", {in_ready, out_valid}, 2'b10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
